// File: rtl/cla_serial_subtractor.sv
// Nibble-serial subtractor: DIFF = A - B - BIN, one 4-bit carry-lookahead slice of A + ~B per clock.
// Defining CLA_SUB_OVF_EN adds a registered signed-overflow flag on ovf; otherwise ovf is tied to 0.
module cla_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [IDXW+1:0]  base;
  logic [3:0]       p, g, sum;
  logic [4:0]       c;
  logic [WIDTH-1:0] diff_new;

  assign base = {idx_q, 2'b00};

  // Lookahead slice on the current nibble of A and ~B, seeded by the carry from the previous nibble.
  always_comb begin
    p    = a_q[base +: 4] ^ nb_q[base +: 4];
    g    = a_q[base +: 4] & nb_q[base +: 4];
    c[0] = carry_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum  = p ^ c[3:0];
    diff_new = diff_q;
    diff_new[base +: 4] = sum;
  end

`ifdef CLA_SUB_OVF_EN
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && idx_q == LAST_IDX) begin
      ovf_d = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (diff_new[WIDTH-1] != a_q[WIDTH-1]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    nb_d    = nb_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = ~bin;
          idx_d   = '0;
          diff_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d  = diff_new;
        carry_d = c[4];
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          bout_d  = ~c[4];
          zero_d  = (diff_new == '0);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      nb_q    <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
endmodule
